// File: rtl/race_timer.sv
// race_timer: per-car lap timer with last/best lap, lap count, race end and timeout.
// Ports: pclk, rst (sync, active low), start, stop, lap_finished, checkpoints_passed,
// current/last/best_lap_time, lap_count, race_done, max_time_exceeded.
// Define RACE_TIMER_DELTA_EN to add lap_delta (signed lap minus previous best).
module race_timer #(
  parameter int CHANNELS = 2,
  parameter int TIME_W   = 16,
  parameter int TICK_DIV = 650000,
  parameter int MAX_TIME = 59999,
  parameter int LAP_W    = 4,
  parameter int LAPS     = 3
) (
  input  logic                         pclk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [CHANNELS-1:0]          lap_finished,
  input  logic [CHANNELS-1:0]          checkpoints_passed,
  output logic [CHANNELS*TIME_W-1:0]   current_lap_time,
  output logic [CHANNELS*TIME_W-1:0]   last_lap_time,
  output logic [CHANNELS*TIME_W-1:0]   best_lap_time,
  output logic [CHANNELS*LAP_W-1:0]    lap_count,
  output logic [CHANNELS-1:0]          race_done,
  output logic [CHANNELS-1:0]          max_time_exceeded
`ifdef RACE_TIMER_DELTA_EN
  ,
  output logic [CHANNELS*(TIME_W+1)-1:0] lap_delta
`endif
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0] TMAX    = TIME_W'(MAX_TIME);
  localparam logic [LAP_W-1:0]  NLAPS   = LAP_W'(LAPS);

  typedef enum logic [1:0] {
    G_IDLE,
    G_RUN,
    G_PAUSE
  } g_state_t;

  typedef enum logic [1:0] {
    CH_ACTIVE,
    CH_DONE,
    CH_TIMEOUT
  } ch_state_t;

  g_state_t      g_state;
  g_state_t      g_next;
  logic          start_q;
  logic          start_rise;
  logic          run;
  logic [PW-1:0] presc;
  logic          tick;

  assign start_rise = start & ~start_q;

  always_ff @(posedge pclk) begin
    if (!rst) g_state <= G_IDLE;
    else      g_state <= g_next;
  end

  always_comb begin
    g_next = g_state;
    unique case (g_state)
      G_IDLE:  if (start_rise) g_next = G_RUN;
      G_RUN:   if (!start) g_next = G_IDLE;
               else if (stop) g_next = G_PAUSE;
      G_PAUSE: if (!start) g_next = G_IDLE;
               else if (!stop) g_next = G_RUN;
      default: g_next = G_IDLE;
    endcase
  end

  always_comb begin
    run = (g_state == G_RUN);
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      start_q <= 1'b0;
      presc   <= '0;
    end else begin
      start_q <= start;
      if (start_rise)
        presc <= '0;
      else if (run)
        presc <= (presc == PRE_MAX) ? '0 : presc + PW'(1);
    end
  end

  assign tick = run & (presc == PRE_MAX);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ch_state_t         st;
    ch_state_t         st_next;
    logic [TIME_W-1:0] cur;
    logic [TIME_W-1:0] last;
    logic [TIME_W-1:0] best;
    logic [LAP_W-1:0]  cnt;
    logic [LAP_W-1:0]  cnt_inc;
    logic              done;
    logic              mte;
    logic              active;
    logic              valid;
    logic              at_limit;

    assign active   = (st == CH_ACTIVE);
    // start must still be high: a lap coinciding with start falling is dropped
    assign valid    = active & run & start
                    & lap_finished[i] & checkpoints_passed[i];
    assign cnt_inc  = cnt + LAP_W'(1);
    assign at_limit = (cur >= TMAX - TIME_W'(1));

    always_ff @(posedge pclk) begin
      if (!rst) st <= CH_ACTIVE;
      else      st <= st_next;
    end

    always_comb begin
      st_next = st;
      if (start_rise)
        st_next = CH_ACTIVE;
      else if (active) begin
        if (valid) begin
          if (cnt_inc == NLAPS) st_next = CH_DONE;
        end else if (tick && at_limit)
          st_next = CH_TIMEOUT;
      end
    end

    always_ff @(posedge pclk) begin
      if (!rst || start_rise) begin
        cur  <= '0;
        last <= '0;
        best <= '1;
        cnt  <= '0;
        done <= 1'b0;
        mte  <= 1'b0;
      end else if (active) begin
        if (valid) begin
          // lap wins over a same-cycle tick
          last <= cur;
          if (cur < best) best <= cur;
          cur  <= '0;
          cnt  <= cnt_inc;
          if (cnt_inc == NLAPS) done <= 1'b1;
        end else if (tick) begin
          if (at_limit) begin
            cur <= TMAX;
            mte <= 1'b1;
          end else begin
            cur <= cur + TIME_W'(1);
          end
        end
      end
    end

`ifdef RACE_TIMER_DELTA_EN
    logic signed [TIME_W:0] delta;

    always_ff @(posedge pclk) begin
      if (!rst || start_rise)
        delta <= '0;
      else if (valid) begin
        // no best yet on the first lap, so report zero
        if (best == '1) delta <= '0;
        else delta <= $signed({1'b0, cur}) - $signed({1'b0, best});
      end
    end

    assign lap_delta[i*(TIME_W+1) +: TIME_W+1] = delta;
`endif

    assign current_lap_time[i*TIME_W +: TIME_W] = cur;
    assign last_lap_time[i*TIME_W +: TIME_W]    = last;
    assign best_lap_time[i*TIME_W +: TIME_W]    = best;
    assign lap_count[i*LAP_W +: LAP_W]          = cnt;
    assign race_done[i]                         = done;
    assign max_time_exceeded[i]                 = mte;
  end

endmodule

// File: tb/tb_race_timer.sv
// tb_race_timer: scoreboard bench for race_timer.
// Small tick divider and lap limit so races finish in a few hundred cycles.
module tb_race_timer;

  localparam int CH = 2;
  localparam int TW = 16;
  localparam int TD = 4;
  localparam int MT = 100;
  localparam int LW = 4;
  localparam int NL = 3;
  localparam int NONE = 65535;

  logic          pclk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CH-1:0] lap_finished = '0;
  logic [CH-1:0] checkpoints_passed = '0;
  logic [CH*TW-1:0] current_lap_time;
  logic [CH*TW-1:0] last_lap_time;
  logic [CH*TW-1:0] best_lap_time;
  logic [CH*LW-1:0] lap_count;
  logic [CH-1:0]    race_done;
  logic [CH-1:0]    max_time_exceeded;
`ifdef RACE_TIMER_DELTA_EN
  logic [CH*(TW+1)-1:0] lap_delta;
`endif

  int n_run = 0;
  int n_fail = 0;
  int k = 0;
  int l0 = 0;

  typedef struct {
    int ch;
    int last;
    int best;
    int cnt;
    int done;
    int cur;
    int delta;
  } exp_t;

  exp_t sb[$];

  always #5 pclk = ~pclk;

  race_timer #(
    .CHANNELS(CH), .TIME_W(TW), .TICK_DIV(TD),
    .MAX_TIME(MT), .LAP_W(LW), .LAPS(NL)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .lap_finished(lap_finished),
    .checkpoints_passed(checkpoints_passed),
    .current_lap_time(current_lap_time),
    .last_lap_time(last_lap_time),
    .best_lap_time(best_lap_time),
    .lap_count(lap_count),
    .race_done(race_done),
    .max_time_exceeded(max_time_exceeded)
`ifdef RACE_TIMER_DELTA_EN
    ,
    .lap_delta(lap_delta)
`endif
  );

  function automatic int f_cur(int i);
    return int'(current_lap_time[i*TW +: TW]);
  endfunction

  function automatic int f_last(int i);
    return int'(last_lap_time[i*TW +: TW]);
  endfunction

  function automatic int f_best(int i);
    return int'(best_lap_time[i*TW +: TW]);
  endfunction

  function automatic int f_cnt(int i);
    return int'(lap_count[i*LW +: LW]);
  endfunction

`ifdef RACE_TIMER_DELTA_EN
  function automatic int f_delta(int i);
    logic signed [TW:0] d;
    d = lap_delta[i*(TW+1) +: TW+1];
    return int'(d);
  endfunction
`endif

  // ticks landing on edges in (a, b], edges counted from the start edge
  function automatic int ticks(int a, int b);
    return b / TD - a / TD;
  endfunction

  task automatic chk(string tag, longint got, longint exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(negedge pclk);
      k++;
    end
  endtask

  task automatic chk_reset(string tag);
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("%s_cur%0d", tag, i), f_cur(i), 0);
      chk($sformatf("%s_last%0d", tag, i), f_last(i), 0);
      chk($sformatf("%s_best%0d", tag, i), f_best(i), NONE);
      chk($sformatf("%s_cnt%0d", tag, i), f_cnt(i), 0);
      chk($sformatf("%s_done%0d", tag, i), race_done[i], 0);
      chk($sformatf("%s_mte%0d", tag, i), max_time_exceeded[i], 0);
`ifdef RACE_TIMER_DELTA_EN
      chk($sformatf("%s_delta%0d", tag, i), f_delta(i), 0);
`endif
    end
  endtask

  task automatic lap(string tag, int ch, bit cp, int e_last, int e_best,
                     int e_cnt, int e_done, int e_cur, int e_delta);
    exp_t e;
    e = '{ch, e_last, e_best, e_cnt, e_done, e_cur, e_delta};
    sb.push_back(e);
    lap_finished[ch] = 1'b1;
    checkpoints_passed[ch] = cp;
    step(1);
    lap_finished = '0;
    checkpoints_passed = '0;
    e = sb.pop_front();
    chk({tag, "_last"}, f_last(e.ch), e.last);
    chk({tag, "_best"}, f_best(e.ch), e.best);
    chk({tag, "_cnt"}, f_cnt(e.ch), e.cnt);
    chk({tag, "_done"}, race_done[e.ch], e.done);
    chk({tag, "_cur"}, f_cur(e.ch), e.cur);
`ifdef RACE_TIMER_DELTA_EN
    chk({tag, "_delta"}, f_delta(e.ch), e.delta);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge pclk);
    rst = 1'b0;
    step(3);
    chk_reset("rst");
    rst = 1'b1;
    step(2);
    chk("idle_cur0", f_cur(0), 0);

    start = 1'b1;
    step(1);
    k = 0;
    step(40);
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("run40_cur%0d", i), f_cur(i), 10);
      chk($sformatf("run40_best%0d", i), f_best(i), NONE);
      chk($sformatf("run40_cnt%0d", i), f_cnt(i), 0);
    end

    lap("lap0_a", 0, 1'b1, 10, 10, 1, 0, 0, 0);
    l0 = k;
    chk("ch1_untouched", f_cur(1), ticks(0, k));
    lap("ch1_nocp", 1, 1'b0, 0, NONE, 0, 0, ticks(0, k + 1), 0);

    while (ticks(l0, k) != 12) step(1);
    chk("pre12_cur0", f_cur(0), 12);
    lap("lap0_b", 0, 1'b1, 12, 10, 2, 0, 0, 2);
    l0 = k;
    while (ticks(l0, k) != 7) step(1);
    lap("lap0_c", 0, 1'b1, 7, 7, 3, 1, 0, -3);
    step(20);
    chk("done_frozen_cur0", f_cur(0), 0);
    lap("lap0_after_done", 0, 1'b1, 7, 7, 3, 1, 0, -3);

    while (k < 399) step(1);
    chk("ch1_pre_cur", f_cur(1), 99);
    chk("ch1_pre_mte", max_time_exceeded[1], 0);
    step(1);
    chk("ch1_sat_cur", f_cur(1), MT);
    chk("ch1_sat_mte", max_time_exceeded[1], 1);
    step(8);
    chk("ch1_hold_cur", f_cur(1), MT);
    chk("ch0_no_mte", max_time_exceeded[0], 0);
    lap("ch1_after_to", 1, 1'b1, 0, NONE, 0, 0, MT, 0);

    start = 1'b0;
    step(2);
    chk("idle_hold_cur1", f_cur(1), MT);
    chk("idle_hold_cnt0", f_cnt(0), 3);
    start = 1'b1;
    step(1);
    k = 0;
    chk_reset("restart");

    step(10);
    chk("pre_pause_cur0", f_cur(0), 2);
    stop = 1'b1;
    step(20);
    chk("pause_cur0", f_cur(0), 2);
    chk("pause_cur1", f_cur(1), 2);
    lap("lap_paused", 0, 1'b1, 0, NONE, 0, 0, 2, 0);
    stop = 1'b0;
    step(2);
    chk("resume_cur0", f_cur(0), 3);

    start = 1'b0;
    lap("lap_start_fall", 0, 1'b1, 0, NONE, 0, 0, 3, 0);
    step(8);
    chk("idle_cur0_b", f_cur(0), 3);

    start = 1'b1;
    step(1);
    k = 0;
    step(20);
    lap("lap_r3", 0, 1'b1, 5, 5, 1, 0, 0, 0);
    step(6);
    rst = 1'b0;
    lap_finished = '1;
    checkpoints_passed = '1;
    step(1);
    chk_reset("midrst");
    rst = 1'b1;
    lap_finished = '0;
    checkpoints_passed = '0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
